// File: rtl/read_word_collector.sv
// Reassembles byte-wise core reads (lanes 0..3) into 32-bit words behind a valid/ready output.
// Optional READ_COLLECTOR_PARITY_EN adds parity_o = ^word_o, registered alongside word_o.
module read_word_collector #(
  parameter int unsigned DATA_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [20:0] instruction_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        busy_o,
  output logic        seq_err_o,
`ifdef READ_COLLECTOR_PARITY_EN
  output logic        parity_o,
`endif
  output logic        overflow_o
);

  // A floating bus must never look like a read, so only a solid 1 qualifies.
  logic       strobe;
  logic [1:0] lane;
  logic       unused_instr;

  assign strobe       = (instruction_i[8] === 1'b1) && (instruction_i[7] === 1'b1);
  assign lane         = instruction_i[12:11];
  assign unused_instr = ^{instruction_i[20:13], instruction_i[10:9], instruction_i[6:0]};

  logic [DATA_LATENCY-1:0]      stb_q;
  logic [DATA_LATENCY-1:0][1:0] lane_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_q  <= '0;
      lane_q <= '0;
    end else begin
      stb_q[0]  <= strobe;
      lane_q[0] <= lane;
      for (int unsigned i = 1; i < DATA_LATENCY; i++) begin
        stb_q[i]  <= stb_q[i-1];
        lane_q[i] <= lane_q[i-1];
      end
    end
  end

  logic       cap;
  logic [1:0] cap_lane;

  assign cap      = stb_q[DATA_LATENCY-1];
  assign cap_lane = lane_q[DATA_LATENCY-1];

  logic [1:0]  exp_q, exp_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        seq_err_q, seq_err_d;
  logic        ovf_q, ovf_d;
  logic        complete;

  always_comb begin
    exp_d     = exp_q;
    asm_d     = asm_q;
    seq_err_d = seq_err_q;
    complete  = 1'b0;
    if (cap) begin
      if (cap_lane == exp_q) begin
        exp_d    = exp_q + 2'd1;
        complete = (cap_lane == 2'd3);
        unique case (cap_lane)
          2'd0:    asm_d[7:0]   = data_i;
          2'd1:    asm_d[15:8]  = data_i;
          2'd2:    asm_d[23:16] = data_i;
          default: ;
        endcase
      end else if (cap_lane == 2'd0) begin
        // An early lane 0 restarts the word rather than wasting the byte.
        asm_d     = {16'h0000, data_i};
        exp_d     = 2'd1;
        seq_err_d = 1'b1;
      end else begin
        asm_d     = '0;
        exp_d     = 2'd0;
        seq_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (valid_q && word_ready_i) begin
      valid_d = 1'b0;
    end
    // Accept frees the register in the same cycle, so a coincident completion still loads.
    if (complete) begin
      if (valid_d) begin
        ovf_d = 1'b1;
      end else begin
        word_d  = {data_i, asm_q};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q     <= 2'd0;
      asm_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      seq_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      exp_q     <= exp_d;
      asm_q     <= asm_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      seq_err_q <= seq_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign busy_o       = (exp_q != 2'd0);
  assign seq_err_o    = seq_err_q;
  assign overflow_o   = ovf_q;

`ifdef READ_COLLECTOR_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^word_d;
    end
  end

  assign parity_o = parity_q;
`endif

endmodule

// File: tb/tb_read_word_collector.sv
// Self-checking bench for read_word_collector: directed scenarios plus randomized traffic
// against a cycle-indexed behavioural model of lane assembly and the output handshake.
module tb_read_word_collector;

  localparam int LAT  = 1;
  localparam int MAXC = 4096;

  logic        clk;
  logic        rst_ni;
  logic [20:0] instruction_i;
  logic [7:0]  data_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        busy_o;
  logic        seq_err_o;
  logic        overflow_o;
`ifdef READ_COLLECTOR_PARITY_EN
  logic        parity_o;
`endif

  read_word_collector #(
    .DATA_LATENCY(LAT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .instruction_i(instruction_i),
    .data_i       (data_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .busy_o       (busy_o),
    .seq_err_o    (seq_err_o),
`ifdef READ_COLLECTOR_PARITY_EN
    .parity_o     (parity_o),
`endif
    .overflow_o   (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Per-cycle record of issued reads; the byte for cycle c appears on data_i at c+LAT.
  bit          h_stb  [MAXC];
  logic [1:0]  h_lane [MAXC];
  logic [7:0]  h_byte [MAXC];

  logic [1:0]  m_exp;
  logic [7:0]  m_bytes [4];
  logic [31:0] m_word;
  bit          m_valid;
  bit          m_serr;
  bit          m_ovf;

  function automatic logic [20:0] mk_ins(input logic [1:0] ln, input bit os, input bit oe);
    logic [20:0] v;
    v       = 21'($urandom);
    v[12:11] = ln;
    v[8]    = os;
    v[7]    = oe;
    return v;
  endfunction

  task automatic model_reset();
    m_exp   = 2'd0;
    m_word  = '0;
    m_valid = 1'b0;
    m_serr  = 1'b0;
    m_ovf   = 1'b0;
    for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
    for (int i = 0; i < MAXC; i++) h_stb[i] = 1'b0;
  endtask

  task automatic model_step(input bit cap, input logic [1:0] ln, input logic [7:0] b,
                            input bit rdy);
    bit          done;
    logic [31:0] w;
    done = 1'b0;
    w    = '0;
    if (cap) begin
      if (ln == m_exp) begin
        m_bytes[ln] = b;
        if (ln == 2'd3) begin
          done = 1'b1;
          w    = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        end
        m_exp = m_exp + 2'd1;
      end else if (ln == 2'd0) begin
        m_bytes[0] = b;
        m_exp      = 2'd1;
        m_serr     = 1'b1;
      end else begin
        m_exp  = 2'd0;
        m_serr = 1'b1;
      end
    end
    if (m_valid && rdy) m_valid = 1'b0;
    if (done) begin
      if (m_valid) m_ovf = 1'b1;
      else begin
        m_word  = w;
        m_valid = 1'b1;
      end
    end
  endtask

  // One clock cycle: apply inputs, advance past the edge, update the model.
  task automatic drive(input logic [20:0] ins, input logic [7:0] byt, input bit rdy);
    bit         cap;
    logic [1:0] ln;
    logic [7:0] b;
    instruction_i = ins;
    word_ready_i  = rdy;
    h_stb[cyc]    = (ins[8] === 1'b1) && (ins[7] === 1'b1);
    h_lane[cyc]   = ins[12:11];
    h_byte[cyc]   = byt;
    cap = (cyc >= LAT) && h_stb[cyc-LAT];
    if (cap) begin
      ln = h_lane[cyc-LAT];
      b  = h_byte[cyc-LAT];
    end else begin
      ln = 2'd0;
      b  = 8'($urandom);
    end
    data_i = b;
    @(posedge clk);
    #1;
    if (rst_ni) model_step(cap, ln, b, rdy);
    cyc++;
  endtask

  task automatic apply_reset();
    rst_ni        = 1'b0;
    instruction_i = '0;
    word_ready_i  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni        = 1'b0;
    instruction_i = '0;
    data_i        = '0;
    word_ready_i  = 1'b0;
    #1;
    n_checks++;
    if (word_o !== 32'h0 || word_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: word=%h valid=%b busy=%b, required 0/0/0",
               word_o, word_valid_o, busy_o);
    end
    n_checks++;
    if (seq_err_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: seq_err=%b overflow=%b, required 0/0", seq_err_o, overflow_o);
    end
`ifdef READ_COLLECTOR_PARITY_EN
    n_checks++;
    if (parity_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_parity: got %b, required 0", parity_o);
    end
`endif
    apply_reset();
  endtask

  task automatic test_single_word();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    for (int k = 0; k < 4 + LAT + 2; k++) begin
      if (k < 4) drive(mk_ins(2'(k), 1'b1, 1'b1), bytes[k], 1'b1);
      else drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
      n_checks++;
      if (word_valid_o !== (k + 1 == 4 + LAT)) begin
        n_fail++;
        $display("FAIL single_valid cycle %0d: got %b, required %b", k + 1, word_valid_o,
                 (k + 1 == 4 + LAT));
      end
      if (k + 1 == 4 + LAT) begin
        n_checks++;
        if (word_o !== 32'h44332211) begin
          n_fail++;
          $display("FAIL single_word: got %h, required 44332211", word_o);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) drive(mk_ins(2'(k), 1'b1, 1'b1), 8'(8'h11 * (k + 1)), 1'b0);
    repeat (LAT) drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (word_valid_o !== 1'b1 || word_o !== 32'h44332211) begin
        n_fail++;
        $display("FAIL hold_word %0d: valid=%b word=%h, required 1/44332211", k, word_valid_o,
                 word_o);
      end
      drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b0);
    end
    drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
    n_checks++;
    if (word_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: valid=%b, required 0", word_valid_o);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 8; k++) drive(mk_ins(2'(k % 4), 1'b1, 1'b1), 8'(k + 1), 1'b0);
    repeat (LAT + 1) drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b0);
    n_checks++;
    if (word_valid_o !== 1'b1 || word_o !== 32'h04030201) begin
      n_fail++;
      $display("FAIL ovf_keep_first: valid=%b word=%h, required 1/04030201", word_valid_o,
               word_o);
    end
    n_checks++;
    if (overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: got %b, required 1", overflow_o);
    end
    drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
    n_checks++;
    if (word_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drain: valid=%b overflow=%b, required 0/1", word_valid_o, overflow_o);
    end
  endtask

  task automatic test_seq_err();
    logic [1:0] bad [3];
    logic [7:0] good [4];
    bad[0] = 2'd0; bad[1] = 2'd1; bad[2] = 2'd3;
    good[0] = 8'hAA; good[1] = 8'hBB; good[2] = 8'hCC; good[3] = 8'hDD;
    apply_reset();
    n_checks++;
    if (seq_err_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_clean: seq_err=%b overflow=%b, required 0/0", seq_err_o, overflow_o);
    end
    for (int k = 0; k < 3; k++) drive(mk_ins(bad[k], 1'b1, 1'b1), 8'h5A, 1'b1);
    repeat (LAT + 1) drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
    n_checks++;
    if (seq_err_o !== 1'b1 || word_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_err: seq_err=%b valid=%b busy=%b, required 1/0/0", seq_err_o,
               word_valid_o, busy_o);
    end
    for (int k = 0; k < 4; k++) drive(mk_ins(2'(k), 1'b1, 1'b1), good[k], 1'b1);
    repeat (LAT) drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
    n_checks++;
    if (word_valid_o !== 1'b1 || word_o !== 32'hDDCCBBAA) begin
      n_fail++;
      $display("FAIL seq_recover: valid=%b word=%h, required 1/ddccbbaa", word_valid_o, word_o);
    end
    drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b [4];
    drive(mk_ins(2'd0, 1'b1, 1'b1), 8'h10, 1'b1);
    drive(mk_ins(2'd1, 1'b1, 1'b1), 8'h20, 1'b1);
    repeat (LAT) drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got %b, required 1", busy_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (word_o !== 32'h0 || word_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        seq_err_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: word=%h valid=%b busy=%b serr=%b ovf=%b, required all 0",
               word_o, word_valid_o, busy_o, seq_err_o, overflow_o);
    end
    model_reset();
    repeat (2) drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
    #2 rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b[k] = 8'($urandom);
      drive(mk_ins(2'(k), 1'b1, 1'b1), b[k], 1'b1);
    end
    repeat (LAT) drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
    n_checks++;
    if (word_valid_o !== 1'b1 || word_o !== {b[3], b[2], b[1], b[0]}) begin
      n_fail++;
      $display("FAIL mid_after: valid=%b word=%h, required 1/%h", word_valid_o, word_o,
               {b[3], b[2], b[1], b[0]});
    end
    drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
  endtask

  task automatic test_idle_z();
    for (int k = 0; k < 10; k++) begin
      drive(21'bz, 8'($urandom), 1'b1);
      n_checks++;
      if (busy_o !== 1'b0 || word_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_z %0d: busy=%b valid=%b, required 0/0", k, busy_o, word_valid_o);
      end
    end
  endtask

`ifdef READ_COLLECTOR_PARITY_EN
  task automatic test_parity();
    for (int k = 0; k < 4; k++) drive(mk_ins(2'(k), 1'b1, 1'b1), (k == 0) ? 8'h01 : 8'h00, 1'b1);
    repeat (LAT) drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
    n_checks++;
    if (word_o !== 32'h1 || parity_o !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_one: word=%h parity=%b, required 00000001/1", word_o, parity_o);
    end
    drive(mk_ins(2'd0, 1'b0, 1'b0), 8'h00, 1'b1);
  endtask
`endif

  task automatic test_random();
    logic [1:0] gen_lane;
    logic [1:0] ln;
    bit         os, oe, rdy;
    gen_lane = 2'd0;
    for (int i = 0; i < 600; i++) begin
      os  = ($urandom_range(0, 3) != 0);
      oe  = ($urandom_range(0, 1) != 0);
      ln  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : gen_lane;
      rdy = ($urandom_range(0, 2) != 0);
      if (os && oe && ln == gen_lane) gen_lane = gen_lane + 2'd1;
      drive(mk_ins(ln, os, oe), 8'($urandom), rdy);
      n_checks++;
      if (word_valid_o !== m_valid || word_o !== m_word) begin
        n_fail++;
        $display("FAIL rand_word cyc %0d: valid=%b word=%h, required %b/%h", cyc, word_valid_o,
                 word_o, m_valid, m_word);
      end
      n_checks++;
      if (busy_o !== (m_exp != 2'd0) || seq_err_o !== m_serr || overflow_o !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_status cyc %0d: busy=%b serr=%b ovf=%b, required %b/%b/%b", cyc,
                 busy_o, seq_err_o, overflow_o, (m_exp != 2'd0), m_serr, m_ovf);
      end
`ifdef READ_COLLECTOR_PARITY_EN
      n_checks++;
      if (parity_o !== ^m_word) begin
        n_fail++;
        $display("FAIL rand_parity cyc %0d: got %b, required %b", cyc, parity_o, ^m_word);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_overflow();
    test_seq_err();
    test_reset_mid();
    test_idle_z();
`ifdef READ_COLLECTOR_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
